ras_ctrl: RTL and testbench

RAS_CTRL -- requirements
Module: ras_ctrl

---
 rtl/ras_ctrl_pkg.sv | 31 +++
 rtl/ras_link_classifier.sv | 50 +++++
 rtl/ras_ctrl.sv | 178 +++++++++++++++++
 tb/tb_ras_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/ras_ctrl_pkg.sv
// Shared definitions for the return-address-stack controller: op codes,
// link register numbers, FSM state encoding and small helpers.
package ras_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_PUSH = 2'd1,
    OP_POP  = 2'd2,
    OP_SWAP = 2'd3
  } ras_op_e;

  typedef enum logic {
    ST_IDLE      = 1'b0,
    ST_SWAP_PUSH = 1'b1
  } ras_state_e;

  localparam logic [4:0] LINK_X1 = 5'd1;
  localparam logic [4:0] LINK_X5 = 5'd5;

  function automatic logic is_link(input logic [4:0] r);
    return (r == LINK_X1) || (r == LINK_X5);
  endfunction

  // Saturating add so the corruption counter can never wrap back to zero
  function automatic logic [3:0] sat_add(input logic [3:0] c, input logic [1:0] inc);
    logic [4:0] s;
    s = {1'b0, c} + {3'b000, inc};
    return (s > 5'd15) ? 4'd15 : s[3:0];
  endfunction

endpackage

// File: rtl/ras_link_classifier.sv
// Combinational jump classifier mapping jal/jalr link usage to a RAS op.
// SWAP is only produced when RAS_COROUTINE_EN is defined.
module ras_link_classifier
  import ras_ctrl_pkg::*;
(
  input  logic       is_jal_i,
  input  logic       is_jalr_i,
  input  logic [4:0] rd_i,
  input  logic [4:0] rs1_i,
  output logic [1:0] op_o
);

  logic rd_link_s;
  logic rs1_link_s;

  assign rd_link_s  = is_link(rd_i);
  assign rs1_link_s = is_link(rs1_i);

  // Classify by which of rd/rs1 name a link register
  always_comb begin
    op_o = OP_NONE;
    if (is_jal_i) begin
      if (rd_link_s) begin
        op_o = OP_PUSH;
      end else begin
        op_o = OP_NONE;
      end
    end else if (is_jalr_i) begin
      case ({rd_link_s, rs1_link_s})
        2'b01:   op_o = OP_POP;
        2'b10:   op_o = OP_PUSH;
        2'b11: begin
          if (rd_i == rs1_i) begin
            op_o = OP_PUSH;
          end else begin
`ifdef RAS_COROUTINE_EN
            op_o = OP_SWAP;
`else
            op_o = OP_PUSH;
`endif
          end
        end
        default: op_o = OP_NONE;
      endcase
    end else begin
      op_o = OP_NONE;
    end
  end

endmodule

// File: rtl/ras_ctrl.sv
// RAS controller: issues push/pop for decoded jumps, tracks the two stages
// past decode for flush rollback. Define RAS_COROUTINE_EN for two-cycle swaps.
module ras_ctrl
  import ras_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic        id_stall,
  input  logic        id_is_jal,
  input  logic        id_is_jalr,
  input  logic [4:0]  id_rd,
  input  logic [4:0]  id_rs1,
  input  logic [31:0] id_pc_add_4,
  input  logic        flush_s1,
  input  logic        flush_s2,
  output logic        ras_push,
  output logic        ras_pop,
  output logic [31:0] ras_pc_add_4,
  output logic        rollback_pop_id,
  output logic        rollback_push_id,
  output logic        rollback_push_ex,
  output logic        stall_req,
  output logic [3:0]  lost_cnt
);

  ras_state_e  state_q, state_d;
  ras_op_e     s1_q, s1_d, s2_q, s2_d;
  ras_op_e     cls_op_s, issue_op_s, s1_eff_s;
  logic [1:0]  cls_raw_s;
  logic [3:0]  lost_q, lost_d;
  logic [31:0] pc_q, pc_d;
  logic        flush_any_s;
  logic        s1_lost_s;
  logic        s2_lost_s;

  ras_link_classifier u_cls (
    .is_jal_i  (id_is_jal),
    .is_jalr_i (id_is_jalr),
    .rd_i      (id_rd),
    .rs1_i     (id_rs1),
    .op_o      (cls_raw_s)
  );

  assign cls_op_s    = ras_op_e'(cls_raw_s);
  assign flush_any_s = flush_s1 | flush_s2;
  assign issue_op_s  = (state_q == ST_IDLE && id_valid && !id_stall && !flush_any_s)
                       ? cls_op_s : OP_NONE;
  // A swap whose push has not happened yet has only popped, so it rolls back as a pop
  assign s1_eff_s    = (state_q == ST_SWAP_PUSH && s1_q == OP_SWAP) ? OP_POP : s1_q;
  assign s1_lost_s   = (s1_eff_s == OP_SWAP);
  assign s2_lost_s   = (s2_q == OP_POP) || (s2_q == OP_SWAP);
  assign lost_cnt    = rst_n ? lost_q : 4'd0;

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
`ifdef RAS_COROUTINE_EN
        if (issue_op_s == OP_SWAP) begin
          state_d = ST_SWAP_PUSH;
        end else begin
          state_d = ST_IDLE;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      ST_SWAP_PUSH: state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // FSM and rollback outputs
  always_comb begin
    ras_push         = 1'b0;
    ras_pop          = 1'b0;
    ras_pc_add_4     = 32'd0;
    stall_req        = 1'b0;
    rollback_pop_id  = 1'b0;
    rollback_push_id = 1'b0;
    rollback_push_ex = 1'b0;
    if (rst_n) begin
      case (state_q)
        ST_IDLE: begin
          case (issue_op_s)
            OP_PUSH: begin
              ras_push     = 1'b1;
              ras_pc_add_4 = id_pc_add_4;
            end
            OP_POP:  ras_pop = 1'b1;
`ifdef RAS_COROUTINE_EN
            OP_SWAP: begin
              ras_pop   = 1'b1;
              stall_req = 1'b1;
            end
`endif
            default: ras_push = 1'b0;
          endcase
        end
        ST_SWAP_PUSH: begin
          if (!flush_any_s) begin
            ras_push     = 1'b1;
            ras_pc_add_4 = pc_q;
          end else begin
            ras_push = 1'b0;
          end
        end
        default: ras_push = 1'b0;
      endcase
      if (flush_any_s) begin
        rollback_push_id = (s1_eff_s == OP_PUSH) || (s1_eff_s == OP_SWAP);
        rollback_pop_id  = (s1_eff_s == OP_POP);
      end else begin
        rollback_push_id = 1'b0;
      end
      if (flush_s2) begin
        rollback_push_ex = (s2_q == OP_PUSH);
      end else begin
        rollback_push_ex = 1'b0;
      end
    end else begin
      ras_push = 1'b0;
    end
  end

  // Tracking slot, corruption counter and swap return-address registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q   <= OP_NONE;
      s2_q   <= OP_NONE;
      lost_q <= 4'd0;
      pc_q   <= 32'd0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      lost_q <= lost_d;
      pc_q   <= pc_d;
    end
  end

  // Slot shifting, flush clearing and lost-count accumulation
  always_comb begin
    s1_d   = s1_q;
    s2_d   = s2_q;
    lost_d = lost_q;
    pc_d   = pc_q;
    if (flush_s2) begin
      s1_d   = OP_NONE;
      s2_d   = OP_NONE;
      lost_d = sat_add(lost_q, {1'b0, s1_lost_s} + {1'b0, s2_lost_s});
    end else if (flush_s1) begin
      s1_d   = OP_NONE;
      lost_d = sat_add(lost_q, {1'b0, s1_lost_s});
    end else if (state_q == ST_IDLE && !id_stall) begin
      s2_d = s1_q;
      s1_d = issue_op_s;
    end else begin
      s1_d = s1_q;
    end
    if (issue_op_s == OP_SWAP) begin
      pc_d = id_pc_add_4;
    end else begin
      pc_d = pc_q;
    end
  end

endmodule

// File: tb/tb_ras_ctrl.sv
// Self-checking bench for ras_ctrl: directed scenarios plus randomized traffic
// compared against a behavioural model of the RAS bookkeeping rules.
module tb_ras_ctrl;

  localparam int OPN = 0;
  localparam int OPU = 1;
  localparam int OPO = 2;
  localparam int OPS = 3;
`ifdef RAS_COROUTINE_EN
  localparam bit COROUTINE = 1'b1;
`else
  localparam bit COROUTINE = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        id_valid = 1'b0, id_stall = 1'b0, id_is_jal = 1'b0, id_is_jalr = 1'b0;
  logic [4:0]  id_rd = 5'd0, id_rs1 = 5'd0;
  logic [31:0] id_pc_add_4 = 32'd0;
  logic        flush_s1 = 1'b0, flush_s2 = 1'b0;
  logic        ras_push, ras_pop, rollback_pop_id, rollback_push_id, rollback_push_ex, stall_req;
  logic [31:0] ras_pc_add_4;
  logic [3:0]  lost_cnt;

  ras_ctrl dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .id_valid         (id_valid),
    .id_stall         (id_stall),
    .id_is_jal        (id_is_jal),
    .id_is_jalr       (id_is_jalr),
    .id_rd            (id_rd),
    .id_rs1           (id_rs1),
    .id_pc_add_4      (id_pc_add_4),
    .flush_s1         (flush_s1),
    .flush_s2         (flush_s2),
    .ras_push         (ras_push),
    .ras_pop          (ras_pop),
    .ras_pc_add_4     (ras_pc_add_4),
    .rollback_pop_id  (rollback_pop_id),
    .rollback_push_id (rollback_push_id),
    .rollback_push_ex (rollback_push_ex),
    .stall_req        (stall_req),
    .lost_cnt         (lost_cnt)
  );

  int total = 0;
  int bad   = 0;

  // Model state: ops in the two stages past decode, pending swap push, lost count
  int          m_s1 = 0, m_s2 = 0, m_lost = 0;
  bit          m_swp = 1'b0;
  logic [31:0] m_pc = 32'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int classify(input bit jal, input bit jalr, input int rd, input int rs1);
    bit rl = (rd == 1) || (rd == 5);
    bit sl = (rs1 == 1) || (rs1 == 5);
    if (jal) return rl ? OPU : OPN;
    if (!jalr) return OPN;
    if (rl && !sl) return OPU;
    if (!rl && sl) return OPO;
    if (rl && sl) return (rd == rs1 || !COROUTINE) ? OPU : OPS;
    return OPN;
  endfunction

  function automatic logic [4:0] pick_reg();
    case ($urandom_range(0, 3))
      0: return 5'd0;
      1: return 5'd1;
      2: return 5'd5;
      default: return 5'($urandom_range(0, 31));
    endcase
  endfunction

  // One clock: drive at negedge, check outputs 1 ns later, advance the model
  task automatic step(input bit rst, input bit v, input bit st, input bit jal, input bit jalr,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [31:0] pc,
                      input bit f1, input bit f2);
    int op, s1e, inc;
    bit e_push, e_pop, e_stall, e_rpi, e_rpo, e_rpx;
    logic [31:0] e_pc;
    int e_lost;
    @(negedge clk);
    rst_n = ~rst; id_valid = v; id_stall = st; id_is_jal = jal; id_is_jalr = jalr;
    id_rd = rd; id_rs1 = rs1; id_pc_add_4 = pc; flush_s1 = f1; flush_s2 = f2;
    #1;
    e_push = 0; e_pop = 0; e_stall = 0; e_rpi = 0; e_rpo = 0; e_rpx = 0; e_pc = 32'd0;
    op = OPN; inc = 0; s1e = m_s1;
    e_lost = rst ? 0 : m_lost;
    if (!rst) begin
      if (m_swp) begin
        if (m_s1 == OPS) s1e = OPO;
        if (!(f1 || f2)) begin e_push = 1; e_pc = m_pc; end
      end else if (v && !st && !f1 && !f2) begin
        op = classify(jal, jalr, int'(rd), int'(rs1));
        if (op == OPU) begin e_push = 1; e_pc = pc; end
        if (op == OPO) e_pop = 1;
        if (op == OPS) begin e_pop = 1; e_stall = 1; end
      end
      if (f1 || f2) begin
        e_rpi = (s1e == OPU) || (s1e == OPS);
        e_rpo = (s1e == OPO);
        if (s1e == OPS) inc++;
      end
      if (f2) begin
        e_rpx = (m_s2 == OPU);
        if (m_s2 == OPO || m_s2 == OPS) inc++;
      end
    end
    check("ras_push", ras_push, e_push);
    check("ras_pop", ras_pop, e_pop);
    check("ras_pc_add_4", ras_pc_add_4, e_pc);
    check("stall_req", stall_req, e_stall);
    check("rollback_push_id", rollback_push_id, e_rpi);
    check("rollback_pop_id", rollback_pop_id, e_rpo);
    check("rollback_push_ex", rollback_push_ex, e_rpx);
    check("lost_cnt", lost_cnt, e_lost);
    if (rst) begin
      m_s1 = OPN; m_s2 = OPN; m_swp = 0; m_pc = 32'd0; m_lost = 0;
    end else begin
      m_lost = (m_lost + inc > 15) ? 15 : m_lost + inc;
      if (f2) begin
        m_s1 = OPN; m_s2 = OPN;
      end else if (f1) begin
        m_s1 = OPN;
      end else if (!m_swp && !st) begin
        m_s2 = m_s1; m_s1 = op;
      end
      if (op == OPS) m_pc = pc;
      m_swp = !m_swp && (op == OPS);
    end
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 5'd0, 5'd0, 32'd0, 0, 0);
  endtask

  initial begin
    step(1, 0, 0, 0, 0, 5'd0, 5'd0, 32'd0, 0, 0);
    step(1, 1, 0, 1, 0, 5'd1, 5'd0, 32'h55, 0, 0);
    // jal x1 pushes its return address in the same cycle
    step(0, 1, 0, 1, 0, 5'd1, 5'd0, 32'h104, 0, 0);
    check("jal_push_pc", ras_pc_add_4, 32'h104);
    idle(); idle();
    // pop then flush_s1 rolls back the pop
    step(0, 1, 0, 0, 1, 5'd0, 5'd1, 32'h300, 0, 0);
    step(0, 0, 0, 0, 0, 5'd0, 5'd0, 32'd0, 1, 0);
    idle();
    // coroutine swap (pop+stall then push) or plain push without the feature
    step(0, 1, 0, 0, 1, 5'd1, 5'd5, 32'h200, 0, 0);
    idle(); idle(); idle();
    // push in S2, pop in S1, flush_s2
    step(0, 1, 0, 1, 0, 5'd5, 5'd0, 32'h400, 0, 0);
    step(0, 1, 0, 0, 1, 5'd0, 5'd5, 32'h404, 0, 0);
    step(0, 0, 0, 0, 0, 5'd0, 5'd0, 32'd0, 0, 1);
    check("lost_after_rollback", lost_cnt, 32'd0);
    // pop reaches S2 then flush_s2, seventeen times
    for (int i = 0; i < 17; i++) begin
      step(0, 1, 0, 0, 1, 5'd0, 5'd1, 32'h500, 0, 0);
      idle();
      step(0, 0, 0, 0, 0, 5'd0, 5'd0, 32'd0, 0, 1);
    end
    idle();
    check("lost_saturated", lost_cnt, 32'd15);
    // reset while a swap push is pending
    step(0, 1, 0, 0, 1, 5'd5, 5'd1, 32'h600, 0, 0);
    step(1, 0, 0, 0, 0, 5'd0, 5'd0, 32'd0, 0, 0);
    idle();
    check("lost_after_reset", lost_cnt, 32'd0);
    // flush during the swap push cycle
    step(0, 1, 0, 0, 1, 5'd1, 5'd5, 32'h700, 0, 0);
    step(0, 0, 0, 0, 0, 5'd0, 5'd0, 32'd0, 1, 0);
    idle(); idle();
    for (int i = 0; i < 3000; i++) begin
      int sel;
      sel = $urandom_range(0, 2);
      step($urandom_range(0, 99) < 1, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 2,
           sel == 0, sel == 1, pick_reg(), pick_reg(), $urandom(),
           $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 6);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
